// File: rtl/apb_requester.sv
// APB3 requester: accepts one command at a time on a valid/ready port, runs the
// SETUP/ACCESS transfer with a bounded PREADY wait, and returns a registered response.
module apb_requester #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic              CmdWrite,
    input  logic [ADDR_W-1:0] CmdAddr,
    input  logic [DATA_W-1:0] CmdData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic              RspErr,
    output logic              RspTimeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_to_cnt;
    logic [CNT_W-1:0]   w_to_cnt_nxt;
    logic               w_to_hit;

    logic [ADDR_W-1:0]  r_paddr;
    logic               r_pwrite;
    logic [DATA_W-1:0]  r_pwdata;
    logic               r_psel;
    logic               r_penable;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_err;
    logic               r_rsp_to;

    logic [ADDR_W-1:0]  w_paddr_nxt;
    logic               w_pwrite_nxt;
    logic [DATA_W-1:0]  w_pwdata_nxt;
    logic               w_psel_nxt;
    logic               w_penable_nxt;
    logic               w_rsp_valid_nxt;
    logic [DATA_W-1:0]  w_rsp_data_nxt;
    logic               w_rsp_err_nxt;
    logic               w_rsp_to_nxt;

    // Last permitted ACCESS cycle still without PREADY; PREADY in that cycle wins.
    assign w_to_hit = TO_EN && !PREADY && (r_to_cnt == CNT_W'(TO_LAST));

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (CmdValid)            w_state_nxt = S_SETUP;
            S_SETUP:                           w_state_nxt = S_ACCESS;
            S_ACCESS: if (PREADY || w_to_hit)  w_state_nxt = S_RESP;
            S_RESP:   if (RspReady)            w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values; everything holds unless the current state changes it
    always_comb begin
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_to_nxt    = r_rsp_to;
        w_to_cnt_nxt    = r_to_cnt;
        case (r_state)
            S_IDLE: begin
                if (CmdValid) begin
                    w_paddr_nxt  = CmdAddr;
                    w_pwrite_nxt = CmdWrite;
                    w_pwdata_nxt = CmdData;
                    w_psel_nxt   = 1'b1;
                end
            end
            S_SETUP: begin
                w_penable_nxt = 1'b1;
                w_to_cnt_nxt  = '0;
            end
            S_ACCESS: begin
                if (!PREADY && (r_to_cnt != CNT_W'(TIMEOUT))) begin
                    w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
                end
                if (PREADY) begin
                    w_rsp_data_nxt  = r_pwrite ? '0 : PRDATA;
                    w_rsp_err_nxt   = PSLVERR;
                    w_rsp_to_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                end else if (w_to_hit) begin
                    w_rsp_data_nxt  = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_to_nxt    = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                end
            end
            S_RESP: begin
                if (RspReady) begin
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_to    <= w_rsp_to_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
        end
    end

    assign CmdReady   = (r_state == S_IDLE);
    assign PADDR      = r_paddr;
    assign PWRITE     = r_pwrite;
    assign PWDATA     = r_pwdata;
    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign RspValid   = r_rsp_valid;
    assign RspData    = r_rsp_data;
    assign RspErr     = r_rsp_err;
    assign RspTimeout = r_rsp_to;

endmodule
